mdr_mem_if: RTL and testbench

MDR_MEM_IF -- requirements
Module: mdr_mem_if

---
 rtl/mdr_mem_if_if.sv | 27 ++
 rtl/mdr_mem_if.sv | 115 +++++++++++
 tb/tb_mdr_mem_if.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/mdr_mem_if_if.sv
// Bundle of MDR datapath and memory handshake signals for mdr_mem_if.
// master: the MDR/memory controller side. slave: the datapath plus memory side.
interface mdr_mem_if_if;
   logic        MDRin;
   logic [31:0] bus_in;
   logic        rd_req;
   logic        wr_req;
   logic [31:0] mem_rdata;
   logic        mem_ack;
   logic [31:0] mdr_q;
   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_wdata;
   logic        busy;
   logic        done;
   logic        err;

   modport master (
      input  MDRin, bus_in, rd_req, wr_req, mem_rdata, mem_ack,
      output mdr_q, mem_rd, mem_wr, mem_wdata, busy, done, err
   );

   modport slave (
      output MDRin, bus_in, rd_req, wr_req, mem_rdata, mem_ack,
      input  mdr_q, mem_rd, mem_wr, mem_wdata, busy, done, err
   );
endinterface

// File: rtl/mdr_mem_if.sv
// Memory data register with a registered read/write strobe controller.
// A strobe is held until mem_ack or until TIMEOUT cycles pass, which aborts
// the transfer and raises the sticky err flag.
module mdr_mem_if #(
   parameter int unsigned TIMEOUT = 15
) (
   input  logic         clk,
   input  logic         clr,
   mdr_mem_if_if.master bus
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;

   localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

   state_e      state_q;
   logic [7:0]  cnt_q;
   logic [31:0] mdr_reg_q;
   logic [31:0] wdata_q;
   logic        rd_q;
   logic        wr_q;
   logic        busy_q;
   logic        done_q;
   logic        err_q;

   // Single FSM process; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q   <= StIdle;
         cnt_q     <= 8'd0;
         mdr_reg_q <= 32'd0;
         wdata_q   <= 32'd0;
         rd_q      <= 1'b0;
         wr_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (bus.MDRin) begin
                  mdr_reg_q <= bus.bus_in;
               end
               // Read wins over a simultaneous write; the write is dropped.
               if (bus.rd_req) begin
                  state_q <= StRead;
                  rd_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  cnt_q   <= 8'd0;
                  err_q   <= 1'b0;
               end else if (bus.wr_req) begin
                  state_q <= StWrite;
                  wr_q    <= 1'b1;
                  busy_q  <= 1'b1;
                  cnt_q   <= 8'd0;
                  err_q   <= 1'b0;
                  // Forward a same-cycle MDR load into the write data.
                  wdata_q <= bus.MDRin ? bus.bus_in : mdr_reg_q;
               end
            end
            StRead: begin
               if (bus.mem_ack) begin
                  mdr_reg_q <= bus.mem_rdata;
                  state_q   <= StIdle;
                  rd_q      <= 1'b0;
                  busy_q    <= 1'b0;
                  done_q    <= 1'b1;
                  cnt_q     <= 8'd0;
               end else if (cnt_q == TimeoutLast) begin
                  state_q <= StIdle;
                  rd_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  cnt_q   <= 8'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            StWrite: begin
               if (bus.mem_ack) begin
                  state_q <= StIdle;
                  wr_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  cnt_q   <= 8'd0;
               end else if (cnt_q == TimeoutLast) begin
                  state_q <= StIdle;
                  wr_q    <= 1'b0;
                  busy_q  <= 1'b0;
                  err_q   <= 1'b1;
                  cnt_q   <= 8'd0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: begin
               state_q <= StIdle;
               rd_q    <= 1'b0;
               wr_q    <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.mdr_q     = mdr_reg_q;
   assign bus.mem_rd    = rd_q;
   assign bus.mem_wr    = wr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_mdr_mem_if.sv
// Directed bench for mdr_mem_if with TIMEOUT=4: a cycle-by-cycle vector table
// followed by hand-written timeout, ack-on-last-cycle and clear sequences.
module tb_mdr_mem_if;

   typedef struct {
      logic        clr;
      logic        mdrin;
      logic [31:0] bus_in;
      logic        rd;
      logic        wr;
      logic [31:0] rdata;
      logic        ack;
      logic [31:0] e_mdr;
      logic [31:0] e_wdata;
      logic        e_rd;
      logic        e_wr;
      logic        e_busy;
      logic        e_done;
      logic        e_err;
   } vec_t;

   localparam int NumVec = 21;

   logic clk;
   logic clr;
   int   checks;
   int   errors;

   mdr_mem_if_if bus_if ();

   mdr_mem_if #(
      .TIMEOUT(4)
   ) dut (
      .clk(clk),
      .clr(clr),
      .bus(bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   vec_t vecs[NumVec];

   function automatic vec_t mk(input logic c, input logic m, input logic [31:0] b,
                               input logic r, input logic w, input logic [31:0] rd_data,
                               input logic a, input logic [31:0] emdr,
                               input logic [31:0] ewd, input logic erd, input logic ewr,
                               input logic ebusy, input logic edone, input logic eerr);
      vec_t v;
      v.clr = c; v.mdrin = m; v.bus_in = b; v.rd = r; v.wr = w; v.rdata = rd_data;
      v.ack = a; v.e_mdr = emdr; v.e_wdata = ewd; v.e_rd = erd; v.e_wr = ewr;
      v.e_busy = ebusy; v.e_done = edone; v.e_err = eerr;
      return v;
   endfunction

   // Apply one cycle of inputs, then sample 1 time unit after the edge.
   task automatic step(input logic c, input logic m, input logic [31:0] b, input logic r,
                       input logic w, input logic [31:0] rd_data, input logic a);
      clr              = c;
      bus_if.MDRin     = m;
      bus_if.bus_in    = b;
      bus_if.rd_req    = r;
      bus_if.wr_req    = w;
      bus_if.mem_rdata = rd_data;
      bus_if.mem_ack   = a;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_step();
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
   endtask

   task automatic check_all(input string name, input logic [31:0] emdr,
                            input logic [31:0] ewd, input logic erd, input logic ewr,
                            input logic ebusy, input logic edone, input logic eerr);
      logic [68:0] act;
      logic [68:0] exp;
      act = {bus_if.mdr_q, bus_if.mem_wdata, bus_if.mem_rd, bus_if.mem_wr, bus_if.busy,
             bus_if.done, bus_if.err};
      exp = {emdr, ewd, erd, ewr, ebusy, edone, eerr};
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got mdr=%h wdata=%h rd=%b wr=%b busy=%b done=%b err=%b, want mdr=%h wdata=%h rd=%b wr=%b busy=%b done=%b err=%b",
                  name, bus_if.mdr_q, bus_if.mem_wdata, bus_if.mem_rd, bus_if.mem_wr,
                  bus_if.busy, bus_if.done, bus_if.err, emdr, ewd, erd, ewr, ebusy, edone,
                  eerr);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, want %0d", name, act, exp);
      end
   endtask

   initial begin
      int n;
      int saw_done;
      checks = 0;
      errors = 0;
      clr = 1'b1;
      bus_if.MDRin = 1'b0; bus_if.bus_in = '0; bus_if.rd_req = 1'b0;
      bus_if.wr_req = 1'b0; bus_if.mem_rdata = '0; bus_if.mem_ack = 1'b0;

      //            clr mdr bus           rd wr rdata         ack | mdr          wdata        rd wr by dn er
      vecs[0]  = mk(1, 0, 32'h0,        0, 0, 32'h0,        0, 32'h0,        32'h0,        0, 0, 0, 0, 0);
      vecs[1]  = mk(0, 1, 32'h2,        0, 0, 32'h0,        0, 32'h2,        32'h0,        0, 0, 0, 0, 0);
      vecs[2]  = mk(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h2,        32'h0,        1, 0, 1, 0, 0);
      vecs[3]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h2,        32'h0,        1, 0, 1, 0, 0);
      vecs[4]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h2,        32'h0,        1, 0, 1, 0, 0);
      vecs[5]  = mk(0, 0, 32'h0,        0, 0, 32'hDEADBEEF, 1, 32'hDEADBEEF, 32'h0,        0, 0, 0, 1, 0);
      vecs[6]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'hDEADBEEF, 32'h0,        0, 0, 0, 0, 0);
      vecs[7]  = mk(0, 1, 32'h12345678, 0, 0, 32'h0,        0, 32'h12345678, 32'h0,        0, 0, 0, 0, 0);
      vecs[8]  = mk(0, 0, 32'h0,        0, 1, 32'h0,        0, 32'h12345678, 32'h12345678, 0, 1, 1, 0, 0);
      vecs[9]  = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h12345678, 32'h12345678, 0, 0, 0, 1, 0);
      vecs[10] = mk(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h12345678, 32'h12345678, 0, 0, 0, 0, 0);
      vecs[11] = mk(0, 0, 32'h0,        1, 1, 32'h0,        0, 32'h12345678, 32'h12345678, 1, 0, 1, 0, 0);
      vecs[12] = mk(0, 1, 32'hFFFF0000, 0, 0, 32'h0,        0, 32'h12345678, 32'h12345678, 1, 0, 1, 0, 0);
      vecs[13] = mk(0, 0, 32'h0,        0, 0, 32'hCAFEF00D, 1, 32'hCAFEF00D, 32'h12345678, 0, 0, 0, 1, 0);
      vecs[14] = mk(0, 1, 32'hA5A5A5A5, 0, 1, 32'h0,        0, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 1, 1, 0, 0);
      vecs[15] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0, 1, 0);
      vecs[16] = mk(0, 0, 32'h0,        0, 0, 32'h0BAD0BAD, 1, 32'hA5A5A5A5, 32'hA5A5A5A5, 0, 0, 0, 0, 0);
      vecs[17] = mk(0, 1, 32'h11112222, 1, 0, 32'h0,        0, 32'h11112222, 32'hA5A5A5A5, 1, 0, 1, 0, 0);
      vecs[18] = mk(0, 0, 32'h0,        0, 0, 32'h33334444, 1, 32'h33334444, 32'hA5A5A5A5, 0, 0, 0, 1, 0);
      vecs[19] = mk(0, 0, 32'h0,        0, 1, 32'h0,        0, 32'h33334444, 32'h33334444, 0, 1, 1, 0, 0);
      vecs[20] = mk(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h33334444, 32'h33334444, 0, 0, 0, 1, 0);

      for (int i = 0; i < NumVec; i++) begin
         step(vecs[i].clr, vecs[i].mdrin, vecs[i].bus_in, vecs[i].rd, vecs[i].wr,
              vecs[i].rdata, vecs[i].ack);
         check_all($sformatf("vec%0d", i), vecs[i].e_mdr, vecs[i].e_wdata, vecs[i].e_rd,
                   vecs[i].e_wr, vecs[i].e_busy, vecs[i].e_done, vecs[i].e_err);
      end

      // Read timeout: strobe held exactly 4 cycles, no done, err set.
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      n = bus_if.mem_rd ? 1 : 0;
      saw_done = 0;
      for (int i = 0; i < 20 && bus_if.mem_rd; i++) begin
         idle_step();
         if (bus_if.done) saw_done = 1;
         if (bus_if.mem_rd) n++;
      end
      check_int("rd_timeout_len", n, 4);
      check_int("rd_timeout_no_done", saw_done, 0);
      check_all("rd_timeout_state", 32'h33334444, 32'h33334444, 0, 0, 0, 0, 1);
      idle_step();
      check_all("err_sticky", 32'h33334444, 32'h33334444, 0, 0, 0, 0, 1);

      // New read clears err; ack on the final allowed cycle completes normally.
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      check_all("rd_clears_err", 32'h33334444, 32'h33334444, 1, 0, 1, 0, 0);
      idle_step();
      idle_step();
      idle_step();
      check_all("rd_last_cycle", 32'h33334444, 32'h33334444, 1, 0, 1, 0, 0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h77778888, 1'b1);
      check_all("ack_on_timeout", 32'h77778888, 32'h33334444, 0, 0, 0, 1, 0);

      // Write timeout: mem_wr held 4 cycles, data held, err set.
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 1'b0);
      n = bus_if.mem_wr ? 1 : 0;
      for (int i = 0; i < 20 && bus_if.mem_wr; i++) begin
         idle_step();
         if (bus_if.mem_wr) n++;
      end
      check_int("wr_timeout_len", n, 4);
      check_all("wr_timeout_state", 32'h77778888, 32'h77778888, 0, 0, 0, 0, 1);

      // Clear in the second read cycle abandons the transfer.
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0);
      idle_step();
      check_all("clr_pre", 32'h77778888, 32'h77778888, 1, 0, 1, 0, 0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
      check_all("clr_mid_read", 32'h0, 32'h0, 0, 0, 0, 0, 0);
      step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h99999999, 1'b1);
      check_all("ack_after_clr", 32'h0, 32'h0, 0, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
